io_uart_tx: RTL
===============

# io_uart_tx

Memory-mapped UART transmitter on the processor's IO write port.
- The core asserts `io_rw` for stores whose address has `[31:24] == 8'hFF`; this block consumes those writes.
- Data bytes are buffered in a FIFO and serialised as 8N1 frames on `uart_tx`.
- A combinational status word lets software poll fullness, emptiness, busy and overflow.

## Interface
- `CLK_DIV`, default 434: clock cycles per bit (50 MHz / 115200); legal range 2..65535.
- `FIFO_DEPTH`, default 16: TX FIFO entries; power of two, 2..256.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: reset is synchronous and active-low.
- `io_rw` in 1: IO write strobe; one write per cycle while high.
- `io_addr` in 32: store address; only `[7:0]` decoded.
- `io_datain` in 32: store data; `[7:0]` used for TXDATA.
- `io_status` out 32: status word, combinational from registered state.
- `uart_tx` out 1: serial line; idle high.

## Operation
- Register map, offsets in `io_addr[7:0]`:
  - `8'h00` TXDATA (write): push `io_datain[7:0]`.
  - `8'h04` STATUS (write): clears overflow; data ignored.
  - All other offsets: writes ignored.
- `io_status` fields:
  - bit0: full.
  - bit1: empty.
  - bit2: busy (FSM not IDLE).
  - bit3: overflow (sticky).
  - `[16:8]`: FIFO count, 0..`FIFO_DEPTH`.
  - All other bits: 0.
- Push rules:
  - A push to a full FIFO is dropped and sets overflow, unless a pop occurs in the same cycle. In that case the push is accepted and the count is unchanged.
  - A simultaneous push and pop on an empty FIFO never bypasses. The FSM only pops when it sees the FIFO non-empty in the registered count.
- FIFO: circular buffer with read and write pointers of `log2(FIFO_DEPTH)` bits, wrapping naturally. Count is kept separately so full and empty are unambiguous.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `uart_tx=1`. If the FIFO is non-empty, pop into the shift register, go to START, and load the bit counter to `CLK_DIV-1`.
  - START: `uart_tx=0` for `CLK_DIV` cycles, then go to DATA with bit index 0.
  - DATA: `uart_tx=shift[0]`, LSB first. Each bit lasts `CLK_DIV` cycles. After bit 7, go to STOP.
  - STOP: `uart_tx=1` for `CLK_DIV` cycles, then go to IDLE.
- Back-to-back frames: if the FIFO is non-empty on STOP exit, IDLE lasts exactly one cycle before the next START.
- `uart_tx` is driven from a register; it is never decoded combinationally.

## Timing
- Reset values: `uart_tx=1`; FIFO empty (count 0, pointers 0); overflow 0; FSM IDLE; `io_status=32'h0000_0002`.
- Reset mid-frame: the line returns high on the edge where `reset_n` is sampled low. The FIFO contents and the partial frame are discarded.
- Push latency: a write at edge N is counted at N. The FSM pops at N+1 and `uart_tx` falls after edge N+2, giving 2 cycles write-to-start-bit latency.
- Frame length: `10*CLK_DIV` cycles (`11*CLK_DIV` with parity), plus 1 IDLE cycle between queued frames.
- Status: reflects state after the most recent edge. Overflow clear and overflow set in the same cycle resolve to set.

## Configuration
- `IO_UART_TX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives even parity (XOR of the 8 data bits) for `CLK_DIV` cycles.
  - Frame becomes 8E1, 11 bits.
- Not defined: 8N1; no PARITY state exists in the RTL.

## Test plan
- `CLK_DIV=4`, write `8'h55` to offset `8'h00`:
  - `uart_tx` low for 4 cycles starting 2 cycles after the write.
  - Then 1,0,1,0,1,0,1,0 at 4 cycles each, then stop high.
  - busy deasserts at cycle 42.
- Write 17 bytes in consecutive cycles with the FSM held busy by a prior frame: count reaches 16, full=1, overflow=1, and the 17th byte never appears on the line.
- With the FIFO full, push in the same cycle as the FSM pop: push accepted, count stays 16, overflow stays 0.
- Write to `8'h04` after an overflow: bit3 clears next cycle. Write to `8'h08`: no state change.
- Assert `reset_n=0` for one cycle mid-DATA: `uart_tx=1` and status `32'h2` after that edge, and no further frame bits are sent.
- With `IO_UART_TX_PARITY_EN`, send `8'h07`: the parity bit is 1 and the frame is 44 cycles at `CLK_DIV=4`.

Source files
------------

// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped UART transmitter, TX FIFO feeding an 8N1 serialiser.
// Define IO_UART_TX_PARITY_EN for 8E1 frames (even parity bit ahead of the stop bit).
module io_uart_tx #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        io_rw,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_datain,
  output logic [31:0] io_status,
  output logic        uart_tx
);

  localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [8:0]  DEPTH_C = 9'(FIFO_DEPTH);
  localparam logic [15:0] DIV_M1  = 16'(CLK_DIV - 1);

`ifdef IO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state, state_nxt;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [8:0]    count;
  logic          overflow;
  logic [7:0]    shift;
  logic [15:0]   clk_cnt;
  logic [2:0]    bit_idx;
  logic          bit_done;
  logic          tx_d;
  logic          pop;
  logic          full, empty;
  logic          wr_txdata, wr_status, push_ok, ovf_set;
  logic          unused_bits;
`ifdef IO_UART_TX_PARITY_EN
  logic          par;
`endif

  assign unused_bits = ^{io_addr[31:8], io_datain[31:8]};

  assign wr_txdata = io_rw && (io_addr[7:0] == 8'h00);
  assign wr_status = io_rw && (io_addr[7:0] == 8'h04);
  assign full      = (count == DEPTH_C);
  assign empty     = (count == 9'd0);
  // A full FIFO still accepts a push when the FSM pops on the same edge.
  assign push_ok   = wr_txdata && (!full || pop);
  assign ovf_set   = wr_txdata && full && !pop;
  assign bit_done  = (clk_cnt == 16'd0);

  assign io_status = {15'd0, count, 4'd0, overflow, (state != IDLE), empty, full};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 9'd0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + 9'd1;
        2'b01:   count <= count - 9'd1;
        default: count <= count;
      endcase
      if (ovf_set)        overflow <= 1'b1;
      else if (wr_status) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= io_datain[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (!empty) state_nxt = START;
      START:  if (bit_done) state_nxt = DATA;
`ifdef IO_UART_TX_PARITY_EN
      DATA:   if (bit_done && bit_idx == 3'd7) state_nxt = PARITY;
      PARITY: if (bit_done) state_nxt = STOP;
`else
      DATA:   if (bit_done && bit_idx == 3'd7) state_nxt = STOP;
`endif
      STOP:   if (bit_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pop only on the registered count, so a same-cycle push never bypasses.
  always_comb begin
    pop  = 1'b0;
    tx_d = 1'b1;
    case (state)
      IDLE:   pop  = !empty;
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift[0];
`ifdef IO_UART_TX_PARITY_EN
      PARITY: tx_d = par;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_cnt <= 16'd0;
      bit_idx <= 3'd0;
      uart_tx <= 1'b1;
    end else begin
      uart_tx <= tx_d;
      if (pop) begin
        clk_cnt <= DIV_M1;
        bit_idx <= 3'd0;
      end else if (state != IDLE) begin
        if (bit_done) begin
          clk_cnt <= DIV_M1;
          if (state == DATA) bit_idx <= bit_idx + 3'd1;
        end else begin
          clk_cnt <= clk_cnt - 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      shift <= fifo_mem[rd_ptr];
`ifdef IO_UART_TX_PARITY_EN
      par   <= ^fifo_mem[rd_ptr];
`endif
    end else if (state == DATA && bit_done) begin
      shift <= {1'b0, shift[7:1]};
    end
  end

endmodule
